// File: rtl/multi_debounce_edge.sv
// Multi-channel debouncer: 2-flop synchronizers, shared sample-tick prescaler,
// per-channel stability counters, and registered edge pulses selected by EDGE_MODE.
module multi_debounce_edge #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned PRESCALE     = 65536,
    parameter int unsigned STABLE_TICKS = 2,
    parameter int unsigned EDGE_MODE    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] signal,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic                pulse_any
);

    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned   CW         = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
    localparam bit            RISE_EN    = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam bit            FALL_EN    = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    generate
        if (EDGE_MODE > 2) begin : g_bad_edge_mode
            $error("multi_debounce_edge: EDGE_MODE=%0d is illegal (0..2)", EDGE_MODE);
        end
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("multi_debounce_edge: CHANNELS=%0d out of range 1..32", CHANNELS);
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("multi_debounce_edge: PRESCALE must be at least 1");
        end
        if (STABLE_TICKS < 1) begin : g_bad_stable
            $error("multi_debounce_edge: STABLE_TICKS must be at least 1");
        end
    endgenerate

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic                pulse_any_q, pulse_any_d;

    // Synchronizers run regardless of en.
    always_comb begin
        sync1_d = signal;
        sync2_d = sync1_q;
    end

    // With PRESCALE=1 the count stays at 0 and tick follows en.
    always_comb begin
        tick    = en && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    pulse_d[i] = sync2_q[i] ? RISE_EN : FALL_EN;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        pulse_any_d = |pulse_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            level_q     <= '0;
            pulse_q     <= '0;
            pulse_any_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            pulse_any_q <= pulse_any_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level     = level_q;
    assign pulse     = pulse_q;
    assign pulse_any = pulse_any_q;

endmodule

// File: tb/tb_multi_debounce_edge.sv
// Scoreboard bench: stimulus queues expected output events, per-DUT monitors
// pop and compare whenever level changes or a pulse appears.
module tb_multi_debounce_edge;

    typedef struct {
        string       nm;
        logic [3:0]  lv;
        logic [3:0]  pl;
        logic        pa;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] sig, sig_m;
    logic [3:0] lv2, pl2, lv0, pl0, lv1, pl1;
    logic       pa2, pa0, pa1;

    int unsigned cyc = 0;
    int unsigned tbase = 0;
    int unsigned c0;
    int unsigned nvec = 0;
    int unsigned nfail = 0;
    exp_t q2[$];
    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] prev2 = '0, prev0 = '0, prev1 = '0;

    multi_debounce_edge #(.CHANNELS(4), .PRESCALE(4), .STABLE_TICKS(3), .EDGE_MODE(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .signal(sig),
        .level(lv2), .pulse(pl2), .pulse_any(pa2));

    multi_debounce_edge #(.CHANNELS(4), .PRESCALE(4), .STABLE_TICKS(3), .EDGE_MODE(0)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .en(en), .signal(sig_m),
        .level(lv0), .pulse(pl0), .pulse_any(pa0));

    multi_debounce_edge #(.CHANNELS(4), .PRESCALE(4), .STABLE_TICKS(3), .EDGE_MODE(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .en(en), .signal(sig_m),
        .level(lv1), .pulse(pl1), .pulse_any(pa1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string nm, input logic [3:0] lv, input logic [3:0] pl,
                                input logic pa, input int unsigned lo, input int unsigned hi);
        exp_t e;
        e.nm = nm; e.lv = lv; e.pl = pl; e.pa = pa; e.lo = lo; e.hi = hi;
        return e;
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b, required %b", nm, act, exp);
        end
    endtask

    task automatic check_evt(input exp_t e, input logic [3:0] lv, input logic [3:0] pl, input logic pa);
        check({e.nm, ".level"}, lv, e.lv);
        check({e.nm, ".pulse"}, pl, e.pl);
        check({e.nm, ".pulse_any"}, {3'b000, pa}, {3'b000, e.pa});
        nvec++;
        if (cyc < e.lo || cyc > e.hi) begin
            nfail++;
            $display("FAIL %s.latency: event at cycle %0d, required cycle %0d..%0d", e.nm, cyc, e.lo, e.hi);
        end
    endtask

    task automatic unexpected(input string tag, input logic [3:0] lv, input logic [3:0] pl);
        nvec++;
        nfail++;
        $display("FAIL %s.unexpected: level=%b pulse=%b at cycle %0d, required no event", tag, lv, pl, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev2 = '0;
        else begin
            if (lv2 != prev2 || pl2 != '0 || pa2) begin
                if (q2.size() == 0) unexpected("mode2", lv2, pl2);
                else begin e = q2.pop_front(); check_evt(e, lv2, pl2, pa2); end
            end
            prev2 = lv2;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev0 = '0;
        else begin
            if (lv0 != prev0 || pl0 != '0 || pa0) begin
                if (q0.size() == 0) unexpected("mode0", lv0, pl0);
                else begin e = q0.pop_front(); check_evt(e, lv0, pl0, pa0); end
            end
            prev0 = lv0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev1 = '0;
        else begin
            if (lv1 != prev1 || pl1 != '0 || pa1) begin
                if (q1.size() == 0) unexpected("mode1", lv1, pl1);
                else begin e = q1.pop_front(); check_evt(e, lv1, pl1, pa1); end
            end
            prev1 = lv1;
        end
    end

    // Returns at the negedge just after a tick edge (prescaler count back at 0).
    task automatic align_tick();
        while (((cyc - tbase) % 4) != 0) @(negedge clk);
    endtask

    task automatic drain(input string tag, input exp_t e);
        nvec++;
        nfail++;
        $display("FAIL %s.%s.timeout: no output event, required level=%b pulse=%b by cycle %0d",
                 tag, e.nm, e.lv, e.pl, e.hi);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sig = '0; sig_m = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset.level", lv2, 4'b0000);
        check("reset.pulse", pl2, 4'b0000);
        check("reset.pulse_any", {3'b000, pa2}, 4'b0000);
        check("reset.m0_level", lv0, 4'b0000);
        check("reset.m1_level", lv1, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; tbase = cyc;
        repeat (6) @(negedge clk);

        c0 = cyc; sig[0] = 1'b1;
        q2.push_back(mk("step", 4'b0001, 4'b0001, 1'b1, c0 + 11, c0 + 14));
        repeat (20) @(negedge clk);

        // Two ticks high, one tick low, then held high.
        sig[1] = 1'b1;
        repeat (8) @(negedge clk);
        sig[1] = 1'b0;
        repeat (4) @(negedge clk);
        c0 = cyc; sig[1] = 1'b1;
        q2.push_back(mk("bounce", 4'b0011, 4'b0010, 1'b1, c0 + 11, c0 + 14));
        repeat (20) @(negedge clk);

        c0 = cyc; sig = 4'b0000;
        q2.push_back(mk("fall", 4'b0000, 4'b0011, 1'b1, c0 + 11, c0 + 14));
        repeat (20) @(negedge clk);

        c0 = cyc; sig = 4'b1010;
        q2.push_back(mk("simul", 4'b1010, 4'b1010, 1'b1, c0 + 11, c0 + 14));
        repeat (20) @(negedge clk);

        align_tick();
        c0 = cyc; sig = 4'b1011;
        q2.push_back(mk("freeze", 4'b1011, 4'b0001, 1'b1, c0 + 32, c0 + 32));
        repeat (8) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1; tbase = cyc;
        repeat (20) @(negedge clk);

        align_tick();
        sig = 4'b1111;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.level", lv2, 4'b0000);
        check("midreset.pulse", pl2, 4'b0000);
        check("midreset.pulse_any", {3'b000, pa2}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1; tbase = cyc;
        q2.push_back(mk("requal", 4'b1111, 4'b1111, 1'b1, cyc + 12, cyc + 12));
        repeat (20) @(negedge clk);

        c0 = cyc; sig_m = 4'b0100;
        q0.push_back(mk("m0rise", 4'b0100, 4'b0100, 1'b1, c0 + 11, c0 + 14));
        q1.push_back(mk("m1rise", 4'b0100, 4'b0000, 1'b0, c0 + 11, c0 + 14));
        repeat (20) @(negedge clk);
        c0 = cyc; sig_m = 4'b0000;
        q0.push_back(mk("m0fall", 4'b0000, 4'b0000, 1'b0, c0 + 11, c0 + 14));
        q1.push_back(mk("m1fall", 4'b0000, 4'b0100, 1'b1, c0 + 11, c0 + 14));
        repeat (25) @(negedge clk);

        while (q2.size() != 0) drain("mode2", q2.pop_front());
        while (q0.size() != 0) drain("mode0", q0.pop_front());
        while (q1.size() != 0) drain("mode1", q1.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/multi_debounce_edge.md
MULTI_DEBOUNCE_EDGE -- requirements
Module: multi_debounce_edge

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter PRESCALE, default 65536: sample-tick period in clk cycles, minimum 1.
REQ-003 Parameter STABLE_TICKS, default 2: consecutive ticks of a differing input required to accept a new level, minimum 1.
REQ-004 Parameter EDGE_MODE, default 0: 0 = rising-edge pulses, 1 = falling-edge pulses, 2 = both edges; 3 is illegal and SHALL be flagged by an elaboration-time check.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  when high, the prescaler and debounce counters advance; when low, they freeze.
REQ-008 signal  input  CHANNELS  raw asynchronous inputs, one bit per channel.
REQ-009 level  output  CHANNELS  debounced level per channel, registered.
REQ-010 pulse  output  CHANNELS  one-clk edge pulse per channel, as selected by EDGE_MODE, registered.
REQ-011 pulse_any  output  1  registered OR of the next-cycle pulse vector, aligned with pulse.

Function
REQ-012 Each signal bit SHALL pass through a 2-flop synchronizer; the synchronized value is s[i]. Synchronizers run regardless of en.
REQ-013 The prescaler SHALL count 0..PRESCALE-1 while en=1 and wrap to 0. tick SHALL be high for the one cycle in which the count equals PRESCALE-1 and en=1. When PRESCALE=1, tick = en.
REQ-014 Each channel SHALL have a counter cnt[i] of width clog2(STABLE_TICKS+1), independent of other channels.
REQ-015 On tick with s[i] == level[i]: cnt[i] <= 0 and level[i] holds. Any agreeing sample therefore cancels a pending change.
REQ-016 On tick with s[i] != level[i] and cnt[i] < STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
REQ-017 On tick with s[i] != level[i] and cnt[i] == STABLE_TICKS-1: level[i] <= s[i] and cnt[i] <= 0 on the same edge.
REQ-018 On non-tick cycles: cnt and level hold.
REQ-019 pulse[i] SHALL be high for exactly one clk, on the same edge at which level[i] changes, if the change matches EDGE_MODE. A 0->1 change qualifies in modes 0 and 2. A 1->0 change qualifies in modes 1 and 2. Otherwise pulse[i]=0.
REQ-020 Several channels changing on the same tick SHALL each pulse in the same cycle; pulse_any=1 in that cycle.
REQ-021 Latency from a clean input transition to the level change is 2 clk (synchronizer) plus the time to the STABLE_TICKS-th subsequent tick: between (STABLE_TICKS-1)*PRESCALE+1 and STABLE_TICKS*PRESCALE clk, with en held high.
REQ-022 Deasserting en SHALL freeze the prescaler count and all cnt values; pulse SHALL read 0 while en=0. Reasserting en resumes from the frozen values.
REQ-023 An input glitch shorter than one tick period that is not captured on a tick SHALL have no effect.

Reset
REQ-024 While rst_n=0, asynchronously: synchronizer flops=0, prescaler=0, cnt=0, level=0, pulse=0, pulse_any=0.
REQ-025 Release of rst_n SHALL take effect on the next clk edge. An input held high through reset SHALL then debounce to level=1 per REQ-021 and produce a rising pulse in modes 0 and 2.
REQ-026 Reset asserted mid-count SHALL discard the pending change; no pulse is emitted for it.

Verification (CHANNELS=4, PRESCALE=4, STABLE_TICKS=3, EDGE_MODE=2 unless stated)
REQ-027 Step: signal[0] 0->1 held, en=1. Required: level[0] rises 9..12 clk plus 2 sync after the step; pulse[0] and pulse_any are high for exactly 1 clk on that edge; other bits stay 0.
REQ-028 Bounce: signal[1] is high for 2 ticks, low for 1 tick, then high. Required: no change at the 2nd tick; level[1] rises only after 3 further consecutive high ticks; exactly one pulse.
REQ-029 Simultaneous: signal[3:0] steps 0000->1010 at once. Required: level=1010 and pulse=1010 in the same cycle.
REQ-030 EDGE_MODE=0, then EDGE_MODE=1, with a 0->1->0 sequence on signal[2]. Required: mode 0 pulses on the rise only; mode 1 pulses on the fall only; level tracks both edges in both modes.
REQ-031 en=0 mid-count after 2 qualifying ticks, held for 20 clk. Required: no level change during the freeze; the change completes on the first tick after en=1.
REQ-032 rst_n pulsed low for 1 clk after 2 qualifying ticks with the input still high. Required: all outputs 0 immediately; level rises only after a full fresh 3-tick qualification.
